ifu_fetch: RTL and testbench

Instruction fetch unit with a 2-entry instruction queue. Owns the PC, issues word fetches to instruction memory over a req/ack handshake, and presents fetched instructions with their PCs to the decode stage, which feeds the immediate extender and control unit. Redirects from the next-PC logic (branch/jal/jalr targets) flush the queue and discard any in-flight fetch.

---
 rtl/ifu_fetch.sv | 130 +++++++++++++
 tb/tb_ifu_fetch.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch: owns the PC, fetches words over req/ack, queues up to two {pc,inst} for decode.
// Ack-to-inst_valid is one cycle; fetching pauses while both queue slots are full.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        clrn,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [1:0]  count_q, count_d;
  entry_t      fifo_q [2];
  entry_t      fifo_d [2];

  logic [31:0] redir_tgt;
  logic        push;
  logic        pop;
  logic        wr_slot;
  logic        unused_bits;

  assign redir_tgt   = {redirect_pc[31:2], 2'b00};
  assign unused_bits = ^redirect_pc[1:0];

  // Request is a function of registered state only, so it cannot glitch on im_ack.
  always_comb begin
    im_req  = 1'b0;
    im_addr = fetch_pc_q;
    case (state_q)
      S_RUN:   im_req = (count_q != 2'd2);
      S_DRAIN: begin
        im_req  = 1'b1;
        im_addr = req_addr_q;
      end
      default: ;
    endcase
  end

  assign inst_valid = (count_q != 2'd0);
  assign inst       = inst_valid ? fifo_q[0].inst : NOP_INST;
  assign inst_pc    = inst_valid ? fifo_q[0].pc   : 32'h0000_0000;

  assign pop     = inst_valid & inst_ready;
  assign push    = (state_q == S_RUN) & im_req & im_ack & ~redirect;
  // Slot 1 only when one entry stays resident; a push never happens at count 2.
  assign wr_slot = count_q[0] & ~pop;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    case (state_q)
      S_IDLE: state_d = S_RUN;
      S_RUN: begin
        if (redirect) begin
          fetch_pc_d = redir_tgt;
          if (im_req && !im_ack) begin
            req_addr_d = fetch_pc_q;
            state_d    = S_DRAIN;
          end
        end else if (push) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
        end
      end
      S_DRAIN: begin
        if (redirect) fetch_pc_d = redir_tgt;
        if (im_ack)   state_d    = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fifo_d[0] = fifo_q[0];
    fifo_d[1] = fifo_q[1];
    count_d   = count_q;
    if (redirect) begin
      count_d = 2'd0;
    end else begin
      if (pop) fifo_d[0] = fifo_q[1];
      if (push) begin
        if (wr_slot) fifo_d[1] = {fetch_pc_q, im_rdata};
        else         fifo_d[0] = {fetch_pc_q, im_rdata};
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      count_q    <= 2'd0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      count_q    <= count_d;
      fifo_q[0]  <= fifo_d[0];
      fifo_q[1]  <= fifo_d[1];
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: per-cycle vector table plus redirect/drain/wrap/reset sequences,
// with a memory model feeding a scoreboard of expected {pc, inst} in fetch order.
module tb_ifu_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack;
  logic [31:0] im_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  int total = 0;
  int bad = 0;
  int lat = 0;
  int wait_cnt;

  ifu_fetch #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut (
    .clk(clk), .clrn(clrn), .im_req(im_req), .im_addr(im_addr), .im_ack(im_ack),
    .im_rdata(im_rdata), .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_ready(inst_ready), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  // Memory: acks after 'lat' wait cycles, data is a function of the address.
  assign im_ack   = im_req && (wait_cnt >= lat);
  assign im_rdata = mem_word(im_addr);
  always @(posedge clk or negedge clrn) begin
    if (!clrn)                 wait_cnt <= 0;
    else if (im_req && !im_ack) wait_cnt <= wait_cnt + 1;
    else                       wait_cnt <= 0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } sb_t;
  sb_t         sb[$];
  logic [31:0] exp_fetch;
  logic [31:0] drop_addr;
  bit          drop;

  // Scoreboard: accepted fetches push, decode pops compare, redirects flush.
  initial begin
    sb_t e;
    exp_fetch = 32'h0;
    drop = 0;
    drop_addr = 32'h0;
    forever begin
      @(negedge clk);
      if (!clrn) begin
        sb.delete();
        exp_fetch = 32'h0;
        drop = 0;
      end else begin
        if (!inst_valid) chk("empty_inst", inst, NOP);
        if (inst_valid && inst_ready) begin
          total++;
          if (sb.size() == 0) begin
            bad++;
            $display("FAIL pop_empty: got pc %h want no valid entry at %0t", inst_pc, $time);
          end else begin
            e = sb.pop_front();
            chk("pop_pc", inst_pc, e.pc);
            chk("pop_inst", inst, e.word);
          end
        end
        if (drop) begin
          chk("drain_req", {31'b0, im_req}, 32'd1);
          chk("drain_addr", im_addr, drop_addr);
        end else if (im_req) begin
          chk("fetch_addr", im_addr, exp_fetch);
        end
        if (redirect) begin
          sb.delete();
          if (!drop) drop_addr = exp_fetch;
          drop = im_req && !im_ack;
          exp_fetch = {redirect_pc[31:2], 2'b00};
        end else if (im_req && im_ack) begin
          if (drop) drop = 0;
          else begin
            sb.push_back({exp_fetch, mem_word(exp_fetch)});
            exp_fetch = exp_fetch + 32'd4;
          end
        end
      end
    end
  end

  task automatic do_reset();
    redirect = 1'b0;
    clrn = 1'b0;
    #1;
    chk("rst_req", {31'b0, im_req}, 32'd0);
    chk("rst_addr", im_addr, 32'h0);
    chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst", inst, NOP);
    chk("rst_pc", inst_pc, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 clrn = 1'b1;
  endtask

  task automatic wait_req(input logic [31:0] a);
    bit found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(posedge clk); #1;
      if (im_req && im_addr == a && !im_ack) found = 1;
    end
    chk("wait_req_seen", {31'b0, found}, 32'd1);
  endtask

  task automatic wait_addr_leave(input logic [31:0] a, input logic [31:0] want);
    bit found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(posedge clk); #1;
      if (im_req && im_addr != a) found = 1;
    end
    chk("leave_seen", {31'b0, found}, 32'd1);
    chk("next_addr", im_addr, want);
  endtask

  task automatic wait_valid_pc(input logic [31:0] want);
    bit found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(posedge clk); #1;
      if (inst_valid) found = 1;
    end
    chk("valid_seen", {31'b0, found}, 32'd1);
    chk("first_pc", inst_pc, want);
  endtask

  typedef struct {
    bit          rst;
    bit          rdy;
    bit          req;
    logic [31:0] addr;
    bit          vld;
    logic [31:0] pc;
  } vec_t;
  vec_t tbl[14];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Row i is sampled after the i-th edge following reset release.
    tbl[0]  = '{1, 1, 1, 32'h0,  0, 32'h0};
    tbl[1]  = '{0, 1, 1, 32'h4,  1, 32'h0};
    tbl[2]  = '{0, 1, 1, 32'h8,  1, 32'h4};
    tbl[3]  = '{0, 1, 1, 32'hC,  1, 32'h8};
    tbl[4]  = '{1, 0, 1, 32'h0,  0, 32'h0};
    tbl[5]  = '{0, 0, 1, 32'h4,  1, 32'h0};
    tbl[6]  = '{0, 0, 0, 32'h8,  1, 32'h0};
    tbl[7]  = '{0, 0, 0, 32'h8,  1, 32'h0};
    tbl[8]  = '{0, 0, 0, 32'h8,  1, 32'h0};
    tbl[9]  = '{0, 0, 0, 32'h8,  1, 32'h0};
    tbl[10] = '{0, 1, 0, 32'h8,  1, 32'h0};
    tbl[11] = '{0, 1, 1, 32'h8,  1, 32'h4};
    tbl[12] = '{0, 1, 1, 32'hC,  1, 32'h8};
    tbl[13] = '{0, 1, 1, 32'h10, 1, 32'hC};

    lat = 0;
    do_reset();
    @(posedge clk); #1;
    chk("idle_req", {31'b0, im_req}, 32'd1);

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].rst) do_reset();
      @(posedge clk); #1;
      inst_ready = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("v%0d_req", i), {31'b0, im_req}, {31'b0, tbl[i].req});
      chk($sformatf("v%0d_addr", i), im_addr, tbl[i].addr);
      chk($sformatf("v%0d_vld", i), {31'b0, inst_valid}, {31'b0, tbl[i].vld});
      chk($sformatf("v%0d_pc", i), inst_pc, tbl[i].vld ? tbl[i].pc : 32'h0);
      chk($sformatf("v%0d_inst", i), inst, tbl[i].vld ? mem_word(tbl[i].pc) : NOP);
    end

    // Slow memory, redirect in the first wait cycle of the fetch at 0x8.
    lat = 3;
    inst_ready = 1'b1;
    do_reset();
    wait_req(32'h8);
    redirect = 1'b1; redirect_pc = 32'h100;
    @(posedge clk); #1;
    redirect = 1'b0;
    chk("a_hold_addr", im_addr, 32'h8);
    chk("a_hold_req", {31'b0, im_req}, 32'd1);
    wait_addr_leave(32'h8, 32'h100);
    wait_valid_pc(32'h100);

    // Redirect to unaligned target while full, with a pop in the same cycle.
    lat = 0;
    inst_ready = 1'b0;
    do_reset();
    repeat (3) begin @(posedge clk); #1; end
    chk("b_full_req", {31'b0, im_req}, 32'd0);
    inst_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 32'h203;
    @(posedge clk); #1;
    redirect = 1'b0;
    chk("b_flushed", {31'b0, inst_valid}, 32'd0);
    chk("b_req", {31'b0, im_req}, 32'd1);
    chk("b_addr", im_addr, 32'h200);
    @(posedge clk); #1;
    chk("b_vld", {31'b0, inst_valid}, 32'd1);
    chk("b_pc", inst_pc, 32'h200);

    // Two redirects inside one drain window.
    lat = 3;
    do_reset();
    wait_req(32'h8);
    redirect = 1'b1; redirect_pc = 32'h40;
    @(posedge clk); #1;
    redirect_pc = 32'h80;
    chk("c_hold_addr", im_addr, 32'h8);
    @(posedge clk); #1;
    redirect = 1'b0;
    wait_addr_leave(32'h8, 32'h80);
    wait_valid_pc(32'h80);

    // Address wrap at the top of the space.
    lat = 0;
    do_reset();
    @(posedge clk); #1;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(posedge clk); #1;
    redirect = 1'b0;
    chk("w_addr_top", im_addr, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    chk("w_addr_wrap", im_addr, 32'h0);
    chk("w_pc", inst_pc, 32'hFFFF_FFFC);
    chk("w_inst", inst, mem_word(32'hFFFF_FFFC));

    // Reset asserted while draining.
    lat = 3;
    do_reset();
    wait_req(32'h8);
    redirect = 1'b1; redirect_pc = 32'h300;
    @(posedge clk); #1;
    redirect = 1'b0;
    chk("d_drain_addr", im_addr, 32'h8);
    do_reset();
    @(posedge clk); #1;
    chk("d_after_req", {31'b0, im_req}, 32'd1);
    chk("d_after_addr", im_addr, 32'h0);

    repeat (20) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
